// File: rtl/rv_trace_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : rv_trace_encoder_if
// Retired-record input and byte-stream output bundle of rv_trace_encoder.
// Rev    : 1.0
// ============================================================================
interface rv_trace_encoder_if;
    logic        i_retire_valid;
    logic [29:0] i_pc;
    logic [31:0] i_instr;
    logic        i_reg_write;
    logic [31:0] i_reg_data;
    logic        i_mem_write;
    logic        i_mem_read;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_drop_count;
    logic        o_busy;

    modport master (
        input  i_retire_valid, i_pc, i_instr, i_reg_write, i_reg_data,
        input  i_mem_write, i_mem_read, i_mem_addr, i_mem_data, i_ready,
        output o_data, o_valid, o_drop_count, o_busy
    );

    modport slave (
        output i_retire_valid, i_pc, i_instr, i_reg_write, i_reg_data,
        output i_mem_write, i_mem_read, i_mem_addr, i_mem_data, i_ready,
        input  o_data, o_valid, o_drop_count, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/rv_trace_encoder.sv
`default_nettype none
// ============================================================================
// Module : rv_trace_encoder
// Retirement-trace packetizer: record FIFO plus little-endian byte serializer.
// Memory fields are built in only when RV_TRACE_ENC_MEM_EN is defined.
// Rev    : 1.0
// ============================================================================
module rv_trace_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    rv_trace_encoder_if.master  bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef struct packed {
        logic        lost;
        logic [2:0]  seq;
        logic [29:0] pc;
        logic [31:0] instr;
        logic        reg_write;
        logic [31:0] reg_data;
`ifdef RV_TRACE_ENC_MEM_EN
        logic        mem_write;
        logic        mem_read;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`endif
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PC    = 3'd2,
        S_INSTR = 3'd3,
        S_RDATA = 3'd4
`ifdef RV_TRACE_ENC_MEM_EN
        ,
        S_MADDR = 3'd5,
        S_MDATA = 3'd6
`endif
    } state_t;

    function automatic state_t next_field(input state_t s, input rec_t r);
        state_t n;
        n = S_IDLE;
        case (s)
            S_HDR:   n = S_PC;
            S_PC:    n = S_INSTR;
            S_INSTR: begin
                if (r.reg_write) n = S_RDATA;
`ifdef RV_TRACE_ENC_MEM_EN
                else if (r.mem_write | r.mem_read) n = S_MADDR;
`endif
                else n = S_IDLE;
            end
`ifdef RV_TRACE_ENC_MEM_EN
            S_RDATA: n = (r.mem_write | r.mem_read) ? S_MADDR : S_IDLE;
            S_MADDR: n = S_MDATA;
`endif
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] stream_byte(input state_t s, input logic [1:0] idx, input rec_t r);
        logic [31:0] word;
        logic [7:0]  hdr;
        hdr = {1'b1, r.lost, r.reg_write, 2'b00, r.seq};
`ifdef RV_TRACE_ENC_MEM_EN
        hdr[4] = r.mem_write;
        hdr[3] = r.mem_read;
`endif
        case (s)
            S_PC:    word = {r.pc, 2'b00};
            S_INSTR: word = r.instr;
            S_RDATA: word = r.reg_data;
`ifdef RV_TRACE_ENC_MEM_EN
            S_MADDR: word = r.mem_addr;
            S_MDATA: word = r.mem_data;
`endif
            default: word = '0;
        endcase
        if (s == S_HDR) return hdr;
        return 8'(word >> {idx, 3'b000});
    endfunction

    rec_t                fifo_mem [FIFO_DEPTH];
    rec_t                shadow_q, shadow_d;
    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]          seq_q, seq_d;
    logic                lost_q, lost_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [7:0]          o_data_q;
    logic                o_valid_q, busy_q;

    logic                w_hs, w_last, w_pop, w_push, w_drop, w_empty, w_full;
    rec_t                w_new_rec;

    always_comb begin
        w_new_rec           = '0;
        w_new_rec.lost      = lost_q;
        w_new_rec.seq       = seq_q;
        w_new_rec.pc        = bus.i_pc;
        w_new_rec.instr     = bus.i_instr;
        w_new_rec.reg_write = bus.i_reg_write;
        w_new_rec.reg_data  = bus.i_reg_data;
`ifdef RV_TRACE_ENC_MEM_EN
        w_new_rec.mem_write = bus.i_mem_write;
        w_new_rec.mem_read  = bus.i_mem_read;
        w_new_rec.mem_addr  = bus.i_mem_addr;
        w_new_rec.mem_data  = bus.i_mem_data;
`endif
    end

`ifndef RV_TRACE_ENC_MEM_EN
    logic w_unused_mem;
    assign w_unused_mem = ^{bus.i_mem_write, bus.i_mem_read, bus.i_mem_addr, bus.i_mem_data};
`endif

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_cnt_w'(FIFO_DEPTH));
    assign w_hs    = o_valid_q & bus.i_ready;
    assign w_last  = w_hs && (state_q != S_IDLE) &&
                     ((state_q == S_HDR) ? 1'b0 : (idx_q == 2'd3)) &&
                     (next_field(state_q, shadow_q) == S_IDLE);
    // A pop either starts from idle or chains straight into the next header
    assign w_pop   = !w_empty && ((state_q == S_IDLE) || w_last);
    assign w_push  = bus.i_retire_valid && (!w_full || w_pop);
    assign w_drop  = bus.i_retire_valid && !w_push;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        seq_d      = seq_q;
        lost_d     = lost_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

        if (w_pop) begin
            shadow_d = fifo_mem[rd_ptr_q];
            state_d  = S_HDR;
            idx_d    = 2'd0;
        end else if (w_hs) begin
            if (state_q == S_HDR) begin
                state_d = S_PC;
                idx_d   = 2'd0;
            end else if (idx_q == 2'd3) begin
                state_d = next_field(state_q, shadow_q);
                idx_d   = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        if (w_push) begin
            seq_d  = seq_q + 3'd1;
            lost_d = 1'b0;
        end else if (w_drop) begin
            lost_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) fifo_mem[wr_ptr_q] <= w_new_rec;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            shadow_q   <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            seq_q      <= 3'd0;
            lost_q     <= 1'b0;
            drop_cnt_q <= 16'd0;
            o_data_q   <= 8'd0;
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_q + c_ptr_w'(w_pop);
            wr_ptr_q   <= wr_ptr_q + c_ptr_w'(w_push);
            seq_q      <= seq_d;
            lost_q     <= lost_d;
            drop_cnt_q <= drop_cnt_d;
            o_data_q   <= stream_byte(state_d, idx_d, shadow_d);
            o_valid_q  <= (state_d != S_IDLE);
            busy_q     <= (count_d != '0) || (state_d != S_IDLE);
        end
    end

    assign bus.o_data       = o_data_q;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_drop_count = drop_cnt_q;
    assign bus.o_busy       = busy_q;
endmodule
`default_nettype wire
